// File: rtl/quick_sort_controller.sv
// Iterative Lomuto quicksort sequencer driving a word-addressed memory port.
// Optional QS_DESCENDING_EN flips the partition compare to sort non-increasing.
module quick_sort_controller #(
    parameter int WORD_SIZE   = 16,
    parameter int STACK_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] A,
    input  logic [WORD_SIZE-1:0] lo,
    input  logic [WORD_SIZE-1:0] hi,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0] stack_pointer
);
    localparam int SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [WORD_SIZE-1:0] ONE     = WORD_SIZE'(1);
    localparam logic [WORD_SIZE-1:0] DEPTH_W = WORD_SIZE'(STACK_DEPTH);

    typedef enum logic [4:0] {
        S_IDLE, S_POP, S_RD_PIV, S_PIV_W, S_PIV_CAP, S_LOOP, S_J_W, S_J_CMP,
        S_I_W, S_I_CAP, S_SW_J, S_FS_RD, S_FS_W, S_FS_CAP, S_FS_WR,
        S_PUSH_L, S_PUSH_R, S_FINISH
    } state_t;

    state_t state_q, state_d;
    logic [WORD_SIZE-1:0] base_q, base_d, lo_q, lo_d, hi_q, hi_d;
    logic [WORD_SIZE-1:0] i_q, i_d, j_q, j_d, piv_q, piv_d, mj_q, mj_d, mi_q, mi_d;
    logic [WORD_SIZE-1:0] sp_q, sp_d, addr_q, addr_d, wdata_q, wdata_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d, ovf_q, ovf_d;
    logic rd_q, rd_d, wr_q, wr_d;

    logic [WORD_SIZE-1:0] stk_lo [STACK_DEPTH];
    logic [WORD_SIZE-1:0] stk_hi [STACK_DEPTH];
    logic                 push_req, push_en;
    logic [SPW-1:0]       push_idx, pop_idx;
    logic [WORD_SIZE-1:0] push_lo, push_hi;
    logic [WORD_SIZE:0]   i_x, lo_x, hi_x;
    logic                 take;

    assign pop_idx = SPW'(sp_q - ONE);
    // One extra bit so i-1 / i+1 bounds never wrap at the index extremes
    assign i_x  = {1'b0, i_q};
    assign lo_x = {1'b0, lo_q};
    assign hi_x = {1'b0, hi_q};

`ifdef QS_DESCENDING_EN
    assign take = mem_rdata > piv_q;
`else
    assign take = mem_rdata < piv_q;
`endif

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        i_d      = i_q;
        j_d      = j_q;
        piv_d    = piv_q;
        mj_d     = mj_q;
        mi_d     = mi_q;
        sp_d     = sp_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        ovf_d    = ovf_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        push_req = 1'b0;
        push_en  = 1'b0;
        push_idx = SPW'(sp_q);
        push_lo  = lo_q;
        push_hi  = hi_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = A;
                    lo_d   = lo;
                    hi_d   = hi;
                    err_d  = 1'b0;
                    ovf_d  = 1'b0;
                    busy_d = 1'b1;
                    if (lo >= hi) begin
                        sp_d    = '0;
                        state_d = S_FINISH;
                    end else begin
                        push_en  = 1'b1;
                        push_idx = '0;
                        push_lo  = lo;
                        push_hi  = hi;
                        sp_d     = ONE;
                        state_d  = S_POP;
                    end
                end
            end
            S_POP: begin
                if (sp_q == '0) begin
                    state_d = S_FINISH;
                end else begin
                    sp_d    = sp_q - ONE;
                    lo_d    = stk_lo[pop_idx];
                    hi_d    = stk_hi[pop_idx];
                    i_d     = stk_lo[pop_idx];
                    j_d     = stk_lo[pop_idx];
                    state_d = S_RD_PIV;
                end
            end
            S_RD_PIV: begin
                rd_d    = 1'b1;
                addr_d  = base_q + hi_q;
                state_d = S_PIV_W;
            end
            S_PIV_W:   state_d = S_PIV_CAP;
            S_PIV_CAP: begin
                piv_d   = mem_rdata;
                state_d = S_LOOP;
            end
            S_LOOP: begin
                if (j_q == hi_q) begin
                    state_d = S_FS_RD;
                end else begin
                    rd_d    = 1'b1;
                    addr_d  = base_q + j_q;
                    state_d = S_J_W;
                end
            end
            S_J_W: state_d = S_J_CMP;
            S_J_CMP: begin
                mj_d = mem_rdata;
                if (take) begin
                    rd_d    = 1'b1;
                    addr_d  = base_q + i_q;
                    state_d = S_I_W;
                end else begin
                    j_d     = j_q + ONE;
                    state_d = S_LOOP;
                end
            end
            S_I_W: state_d = S_I_CAP;
            S_I_CAP: begin
                mi_d    = mem_rdata;
                wr_d    = 1'b1;
                addr_d  = base_q + i_q;
                wdata_d = mj_q;
                state_d = S_SW_J;
            end
            S_SW_J: begin
                wr_d    = 1'b1;
                addr_d  = base_q + j_q;
                wdata_d = mi_q;
                i_d     = i_q + ONE;
                j_d     = j_q + ONE;
                state_d = S_LOOP;
            end
            S_FS_RD: begin
                if (i_q == hi_q) begin
                    state_d = S_PUSH_L;
                end else begin
                    rd_d    = 1'b1;
                    addr_d  = base_q + i_q;
                    state_d = S_FS_W;
                end
            end
            S_FS_W: state_d = S_FS_CAP;
            S_FS_CAP: begin
                mi_d    = mem_rdata;
                wr_d    = 1'b1;
                addr_d  = base_q + i_q;
                wdata_d = piv_q;
                state_d = S_FS_WR;
            end
            S_FS_WR: begin
                wr_d    = 1'b1;
                addr_d  = base_q + hi_q;
                wdata_d = mi_q;
                state_d = S_PUSH_L;
            end
            S_PUSH_L: begin
                state_d = S_PUSH_R;
                if (i_x > lo_x + {1'b0, ONE}) begin
                    push_req = 1'b1;
                    push_lo  = lo_q;
                    push_hi  = i_q - ONE;
                end
            end
            S_PUSH_R: begin
                state_d = S_POP;
                if (i_x + {1'b0, ONE} < hi_x) begin
                    push_req = 1'b1;
                    push_lo  = i_q + ONE;
                    push_hi  = hi_q;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                err_d   = ovf_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A full stack aborts the sort rather than dropping a partition
        if (push_req) begin
            if (sp_q >= DEPTH_W) begin
                ovf_d   = 1'b1;
                state_d = S_FINISH;
            end else begin
                push_en = 1'b1;
                sp_d    = sp_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            piv_q   <= '0;
            mj_q    <= '0;
            mi_q    <= '0;
            sp_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            i_q     <= i_d;
            j_q     <= j_d;
            piv_q   <= piv_d;
            mj_q    <= mj_d;
            mi_q    <= mi_d;
            sp_q    <= sp_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            stk_lo[push_idx] <= push_lo;
            stk_hi[push_idx] <= push_hi;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = err_q;
    assign mem_addr      = addr_q;
    assign mem_rd_en     = rd_q;
    assign mem_wr_en     = wr_q;
    assign mem_wdata     = wdata_q;
    assign stack_pointer = sp_q;
endmodule

// File: tb/tb_quick_sort_controller.sv
// Scoreboard bench: two controllers (deep and 2-entry stack) on private memory models.
module tb_quick_sort_controller;
    typedef int wq_t[$];
    typedef struct {
        logic [15:0]       base;
        int                n;
        logic [15:0][15:0] d;
        logic              err;
        logic [15:0]       sp;
        int                lat;
        int                strb;
        int                c0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start0, start1;
    logic [15:0] a0, lo0, hi0, a1, lo1, hi1;
    logic        busy0, done0, err0, rd0, wr0, busy1, done1, err1, rd1, wr1;
    logic [15:0] addr0, wdata0, rdata0, sp0, addr1, wdata1, rdata1, sp1;

    quick_sort_controller u0 (
        .clk(clk), .reset(reset), .start(start0), .A(a0), .lo(lo0), .hi(hi0),
        .busy(busy0), .done(done0), .error(err0), .mem_addr(addr0),
        .mem_rd_en(rd0), .mem_wr_en(wr0), .mem_wdata(wdata0),
        .mem_rdata(rdata0), .stack_pointer(sp0)
    );

    quick_sort_controller #(.WORD_SIZE(16), .STACK_DEPTH(2)) u1 (
        .clk(clk), .reset(reset), .start(start1), .A(a1), .lo(lo1), .hi(hi1),
        .busy(busy1), .done(done1), .error(err1), .mem_addr(addr1),
        .mem_rd_en(rd1), .mem_wr_en(wr1), .mem_wdata(wdata1),
        .mem_rdata(rdata1), .stack_pointer(sp1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    logic        ld_en, ld_sel;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;

    always @(posedge clk) begin
        if (rd0) rdata0 <= mem0[addr0[7:0]];
        if (wr0) mem0[addr0[7:0]] <= wdata0;
        if (rd1) rdata1 <= mem1[addr1[7:0]];
        if (wr1) mem1[addr1[7:0]] <= wdata1;
        if (ld_en && !ld_sel) mem0[ld_addr] <= ld_data;
        if (ld_en && ld_sel)  mem1[ld_addr] <= ld_data;
    end

    int   checks = 0, errors = 0;
    int   strb0 = 0, strb1 = 0, both_cnt = 0;
    exp_t q0[$], q1[$];

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endfunction

    function automatic void check_job(input exp_t e, input logic sel, input logic ge,
                                      input logic [15:0] gsp, input logic gbusy, input int strb);
        chk("error_at_done", 64'(ge), 64'(e.err));
        chk("stack_pointer_at_done", 64'(gsp), 64'(e.sp));
        chk("busy_low_at_done", 64'(gbusy), 64'(0));
        if (e.lat >= 0) chk("done_latency", 64'(cyc - e.c0), 64'(e.lat));
        if (e.strb >= 0) chk("strobe_count", 64'(strb), 64'(e.strb));
        for (int k = 0; k < e.n; k++) begin
            logic [7:0]  ma;
            logic [15:0] got;
            ma  = e.base[7:0] + 8'(k);
            got = sel ? mem1[ma] : mem0[ma];
            chk($sformatf("mem[%0h]", ma), 64'(got), 64'(e.d[k]));
        end
    endfunction

    // Monitor: pops an expectation whenever a controller reports done
    always @(negedge clk) begin
        if (rd0 && wr0) both_cnt++;
        if (rd1 && wr1) both_cnt++;
        if (start0 && !busy0) strb0 = 0; else if (rd0 || wr0) strb0++;
        if (start1 && !busy1) strb1 = 0; else if (rd1 || wr1) strb1++;
        if (done0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL done0_without_job: got done=1 expected no done");
            end else check_job(q0.pop_front(), 1'b0, err0, sp0, busy0, strb0);
        end
        if (done1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL done1_without_job: got done=1 expected no done");
            end else check_job(q1.pop_front(), 1'b1, err1, sp1, busy1, strb1);
        end
    end

    task automatic load(input logic sel, input logic [7:0] base, input wq_t d);
        for (int k = 0; k < d.size(); k++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_sel = sel; ld_addr = base + 8'(k); ld_data = 16'(d[k]);
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_job(input logic sel, input logic [15:0] base, input logic [15:0] lo_v,
                           input logic [15:0] hi_v, input wq_t din, input wq_t dexp,
                           input logic eerr, input logic [15:0] esp, input int elat,
                           input int estrb, input bit poke);
        exp_t e;
        load(sel, base[7:0], din);
        e.base = base; e.n = dexp.size(); e.d = '0;
        for (int k = 0; k < dexp.size(); k++) e.d[k] = 16'(dexp[k]);
        e.err = eerr; e.sp = esp; e.lat = elat; e.strb = estrb;
        @(posedge clk); #1;
        e.c0 = cyc;
        if (sel) begin a1 = base; lo1 = lo_v; hi1 = hi_v; start1 = 1'b1; q1.push_back(e); end
        else     begin a0 = base; lo0 = lo_v; hi0 = hi_v; start0 = 1'b1; q0.push_back(e); end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        if (poke) begin
            // A start while busy must be ignored
            repeat (20) @(posedge clk);
            #1; a0 = 16'h0; lo0 = 16'd0; hi0 = 16'd5; start0 = 1'b1;
            @(posedge clk); #1; start0 = 1'b0;
        end
        for (int k = 0; k < 20000 && (sel ? q1.size() : q0.size()) != 0; k++) @(negedge clk);
        if ((sel ? q1.size() : q0.size()) != 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done within 20000 cycles");
            if (sel) q1.delete(); else q0.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        reset = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        start0 = 1'b0; start1 = 1'b0;
        a0 = '0; lo0 = '0; hi0 = '0; a1 = '0; lo1 = '0; hi1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_u0", 64'({busy0, done0, err0, rd0, wr0, addr0, wdata0, sp0}), 64'(0));
        chk("reset_outputs_u1", 64'({busy1, done1, err1, rd1, wr1, addr1, wdata1, sp1}), 64'(0));
        reset = 1'b0;

        run_job(1'b0, 16'h10, 16'd0, 16'd7, '{5, 3, 8, 1, 9, 2, 7, 4},
                '{1, 2, 3, 4, 5, 7, 8, 9}, 1'b0, 16'd0, -1, -1, 1'b1);
        run_job(1'b0, 16'h30, 16'd3, 16'd3, '{9, 8, 7, 6, 5}, '{9, 8, 7, 6, 5},
                1'b0, 16'd0, 2, 0, 1'b0);
        run_job(1'b0, 16'h20, 16'd0, 16'd15,
                '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
                '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15}, 1'b0, 16'd0, -1, -1, 1'b0);
        run_job(1'b0, 16'h60, 16'd0, 16'd15,
                '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0},
                '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15}, 1'b0, 16'd0, -1, -1, 1'b0);
        run_job(1'b0, 16'h80, 16'd0, 16'd4, '{7, 7, 7, 7, 7}, '{7, 7, 7, 7, 7},
                1'b0, 16'd0, -1, -1, 1'b0);
`ifdef QS_DESCENDING_EN
        run_job(1'b0, 16'h90, 16'd0, 16'd3, '{5, 3, 8, 1}, '{8, 5, 3, 1}, 1'b0, 16'd0, -1, -1, 1'b0);
`else
        run_job(1'b0, 16'h90, 16'd0, 16'd3, '{5, 3, 8, 1}, '{1, 3, 5, 8}, 1'b0, 16'd0, -1, -1, 1'b0);
`endif

        // Two-entry stack: the right half of the second partition cannot be pushed
`ifndef QS_DESCENDING_EN
        run_job(1'b1, 16'h00, 16'd0, 16'd7, '{0, 1, 5, 7, 3, 6, 4, 2},
                '{0, 1, 2, 3, 4, 5, 7, 6}, 1'b1, 16'd2, -1, -1, 1'b0);
        repeat (4) @(negedge clk);
        chk("error_held_after_done", 64'(err1), 64'(1));
        run_job(1'b1, 16'h10, 16'd0, 16'd1, '{2, 1}, '{1, 2}, 1'b0, 16'd0, -1, 5, 1'b0);
`endif

        // Abort a sort with reset while a write strobe is out
        load(1'b0, 8'h40, '{5, 3, 8, 1});
        @(posedge clk); #1;
        a0 = 16'h40; lo0 = 16'd0; hi0 = 16'd3; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 500 && !seen; k++) begin
                @(negedge clk);
                if (wr0) seen = 1'b1;
            end
            chk("write_strobe_before_abort", 64'(seen), 64'(1));
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("outputs_after_abort", 64'({busy0, done0, err0, rd0, wr0, addr0, wdata0, sp0}), 64'(0));
        reset = 1'b0;
        `ifdef QS_DESCENDING_EN
        run_job(1'b0, 16'h50, 16'd0, 16'd1, '{1, 2}, '{2, 1}, 1'b0, 16'd0, -1, 5, 1'b0);
        `else
        run_job(1'b0, 16'h50, 16'd0, 16'd1, '{2, 1}, '{1, 2}, 1'b0, 16'd0, -1, 5, 1'b0);
        `endif

        chk("rd_wr_same_cycle_count", 64'(both_cnt), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
